// File: rtl/data_mem_responder.sv
// Byte-addressed data memory behind a valid/ready request/response handshake.
// Each access takes LATENCY wait cycles and returns a RISC-V-style sized/extended load result.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state, w_state_next;
  logic [3:0]              r_count, w_count_next;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [2:0]              r_funct3;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    w_accept, w_exec, w_err, w_wr, w_rd;
  logic [LANES-1:0]        w_be;
  logic [DATA_WIDTH-1:0]   w_wdata_sh, w_rd_word, w_load;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [ADDR_WIDTH-3:0]   w_widx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_funct3 <= req_funct3;
        r_wdata  <= req_wdata;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_accept     = 1'b0;
    w_exec       = 1'b0;
    case (r_state)
      S_IDLE: if (req_valid) begin
        w_accept     = 1'b1;
        w_state_next = S_WAIT;
        w_count_next = 4'(LATENCY - 1);
      end
      S_WAIT: if (r_count == 4'd0) begin
        w_exec       = 1'b1;
        w_state_next = S_RESP;
      end else begin
        w_count_next = r_count - 4'd1;
      end
      S_RESP: if (resp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);

  // Legality: unsigned loads exist only for reads; size must be naturally aligned.
  always_comb begin
    w_err = 1'b1;
    case (r_funct3)
      3'b000:         w_err = 1'b0;
      3'b001:         w_err = r_addr[0];
      3'b010:         w_err = (r_addr[1:0] != 2'b00);
      3'b100:         w_err = r_we;
      3'b101:         w_err = r_we || r_addr[0];
      default:        w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_be       = '0;
    w_wdata_sh = '0;
    case (r_funct3[1:0])
      2'b00: begin
        w_be       = 4'b0001 << r_addr[1:0];
        w_wdata_sh = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be       = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_sh = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be       = 4'b1111;
        w_wdata_sh = r_wdata;
      end
      default: ;
    endcase
  end

  assign w_widx = r_addr[ADDR_WIDTH-1:2];
  assign w_wr   = w_exec && r_we && !w_err;
  assign w_rd   = w_exec && !r_we;

  // One byte-wide RAM per lane so byte enables map onto independent write ports.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] r_bytes [DEPTH];
      logic [7:0] r_q;
      always_ff @(posedge clk) begin
        if (w_wr && w_be[gi]) r_bytes[w_widx] <= w_wdata_sh[8*gi +: 8];
        if (w_rd) r_q <= r_bytes[w_widx];
      end
      assign w_rd_word[8*gi +: 8] = r_q;
    end
  endgenerate

  always_comb begin
    w_byte = w_rd_word[7:0];
    case (r_addr[1:0])
      2'b01:   w_byte = w_rd_word[15:8];
      2'b10:   w_byte = w_rd_word[23:16];
      2'b11:   w_byte = w_rd_word[31:24];
      default: w_byte = w_rd_word[7:0];
    endcase
    w_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    w_load = '0;
    case (r_funct3)
      3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b010:  w_load = w_rd_word;
      3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load = '0;
    endcase
  end

  assign resp_rdata = (resp_valid && !r_we && !w_err) ? w_load : '0;
  assign resp_err   = resp_valid && w_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance and a LATENCY=1 instance
// driven from one vector table plus hand-written stall/reset sequences.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_we;
  logic [11:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        req_valid0, req_valid1, resp_ready0, resp_ready1;
  logic        req_ready0, req_ready1, resp_valid0, resp_valid1, resp_err0, resp_err1;
  logic [31:0] resp_rdata0, resp_rdata1;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0),
    .resp_err(resp_err0)
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1),
    .resp_err(resp_err1)
  );

  typedef struct {
    bit          sel;
    logic        we;
    logic [11:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input bit sel, input logic we, input logic [11:0] addr,
                              input logic [2:0] f3, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    vec_t v;
    v.sel = sel; v.we = we; v.addr = addr; v.f3 = f3; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},  32'(req_ready0),  32'd1);
    check({tag, " resp_valid"}, 32'(resp_valid0), 32'd0);
    check({tag, " resp_rdata"}, resp_rdata0,      32'd0);
    check({tag, " resp_err"},   32'(resp_err0),   32'd0);
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic do_req(input bit sel, input logic we, input logic [11:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
    req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    check("req_ready before accept", 32'(sel ? req_ready1 : req_ready0), 32'd1);
    @(posedge clk); #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    lat = 0;
    while (!(sel ? resp_valid1 : resp_valid0) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = sel ? resp_rdata1 : resp_rdata0;
    err = sel ? resp_err1 : resp_err0;
    if (sel ? resp_valid1 : resp_valid0) begin
      if (sel) resp_ready1 = 1'b1; else resp_ready0 = 1'b1;
      @(posedge clk); #1;
      resp_ready0 = 1'b0; resp_ready1 = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    // dut0 = LATENCY 2, dut1 = LATENCY 1
    vecs.push_back(mk(0, 1, 12'h010, 3'b010, 32'hDEADBEEF, 32'h0,        0, 2)); // SW
    vecs.push_back(mk(0, 0, 12'h010, 3'b010, 32'h0,        32'hDEADBEEF, 0, 2)); // LW
    vecs.push_back(mk(0, 0, 12'h013, 3'b000, 32'h0,        32'hFFFFFFDE, 0, 2)); // LB
    vecs.push_back(mk(0, 0, 12'h013, 3'b100, 32'h0,        32'h000000DE, 0, 2)); // LBU
    vecs.push_back(mk(0, 0, 12'h012, 3'b001, 32'h0,        32'hFFFFDEAD, 0, 2)); // LH
    vecs.push_back(mk(0, 0, 12'h010, 3'b101, 32'h0,        32'h0000BEEF, 0, 2)); // LHU
    vecs.push_back(mk(0, 1, 12'h011, 3'b000, 32'hFFFFFF55, 32'h0,        0, 2)); // SB
    vecs.push_back(mk(0, 0, 12'h010, 3'b010, 32'h0,        32'hDEAD55EF, 0, 2)); // LW
    vecs.push_back(mk(0, 1, 12'h011, 3'b001, 32'h0000AAAA, 32'h0,        1, 2)); // SH misaligned
    vecs.push_back(mk(0, 0, 12'h010, 3'b010, 32'h0,        32'hDEAD55EF, 0, 2)); // LW unchanged
    vecs.push_back(mk(0, 0, 12'h012, 3'b010, 32'h0,        32'h0,        1, 2)); // LW misaligned
    vecs.push_back(mk(0, 0, 12'h011, 3'b101, 32'h0,        32'h0,        1, 2)); // LHU misaligned
    vecs.push_back(mk(0, 0, 12'h010, 3'b011, 32'h0,        32'h0,        1, 2)); // illegal load
    vecs.push_back(mk(0, 1, 12'h010, 3'b100, 32'h0,        32'h0,        1, 2)); // illegal store
    vecs.push_back(mk(0, 0, 12'h010, 3'b010, 32'h0,        32'hDEAD55EF, 0, 2)); // LW unchanged
    vecs.push_back(mk(0, 1, 12'h016, 3'b001, 32'h1234CAFE, 32'h0,        0, 2)); // SH upper half
    vecs.push_back(mk(0, 0, 12'h016, 3'b101, 32'h0,        32'h0000CAFE, 0, 2)); // LHU
    vecs.push_back(mk(0, 0, 12'h016, 3'b000, 32'h0,        32'hFFFFFFFE, 0, 2)); // LB
    vecs.push_back(mk(0, 0, 12'h017, 3'b000, 32'h0,        32'hFFFFFFCA, 0, 2)); // LB
    vecs.push_back(mk(1, 1, 12'h010, 3'b010, 32'hCAFEF00D, 32'h0,        0, 1)); // SW lat1
    vecs.push_back(mk(1, 0, 12'h010, 3'b010, 32'h0,        32'hCAFEF00D, 0, 1)); // LW lat1
    vecs.push_back(mk(1, 0, 12'h011, 3'b100, 32'h0,        32'h000000F0, 0, 1)); // LBU lat1
    vecs.push_back(mk(1, 0, 12'h010, 3'b011, 32'h0,        32'h0,        1, 1)); // illegal lat1

    rst = 1'b1;
    req_valid0 = 1'b0; req_valid1 = 1'b0; resp_ready0 = 1'b0; resp_ready1 = 1'b0;
    req_we = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset dut1 req_ready", 32'(req_ready1), 32'd1);
    check("reset dut1 resp_valid", 32'(resp_valid1), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_req(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd, rd, err, lat);
      $display("txn %0d dut%0d we=%0b addr=%h f3=%b wd=%h -> rdata=%h err=%0b lat=%0d",
               i, vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd, rd, err, lat);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Stall in RESP with a competing request present; it must not be taken.
    req_we = 1'b0; req_addr = 12'h010; req_funct3 = 3'b010; req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    lat = 0;
    while (!resp_valid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall latency", 32'(lat), 32'd2);
    req_we = 1'b1; req_wdata = 32'h11111111; req_valid0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d resp_valid", k), 32'(resp_valid0), 32'd1);
      check($sformatf("stall%0d rdata", k), resp_rdata0, 32'hDEAD55EF);
      check($sformatf("stall%0d req_ready", k), 32'(req_ready0), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready0 = 1'b1;
    @(posedge clk); #1;
    resp_ready0 = 1'b0;
    check("post-handshake req_ready", 32'(req_ready0), 32'd1);
    check("post-handshake resp_valid", 32'(resp_valid0), 32'd0);
    req_valid0 = 1'b0;
    $display("txn stall LW 0x010 held 5 cycles with competing SW");
    do_req(0, 0, 12'h010, 3'b010, 32'h0, rd, err, lat);
    $display("txn LW 0x010 after stall -> rdata=%h err=%0b lat=%0d", rd, err, lat);
    check("after stall LW", rd, 32'hDEAD55EF);

    // Reset during WAIT must abort a pending store.
    do_req(0, 1, 12'h020, 3'b010, 32'h0, rd, err, lat);
    $display("txn SW 0x020 0 -> err=%0b lat=%0d", err, lat);
    check("clear 0x020 err", 32'(err), 32'd0);
    req_we = 1'b1; req_addr = 12'h020; req_funct3 = 3'b010; req_wdata = 32'h12345678;
    req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    check("abort accepted", 32'(req_ready0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst in WAIT");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("txn SW 0x020 0x12345678 aborted by reset");
    do_req(0, 0, 12'h020, 3'b010, 32'h0, rd, err, lat);
    $display("txn LW 0x020 -> rdata=%h err=%0b lat=%0d", rd, err, lat);
    check("aborted store LW", rd, 32'h0);
    check("aborted store latency", 32'(lat), 32'd2);

    // Reset during RESP drops the response; acceptance resumes on the next edge.
    req_we = 1'b0; req_addr = 12'h010; req_funct3 = 3'b010; req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    lat = 0;
    while (!resp_valid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("pre-drop rdata", resp_rdata0, 32'hDEAD55EF);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst in RESP");
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn LW 0x010 dropped by reset in RESP");
    do_req(0, 0, 12'h016, 3'b101, 32'h0, rd, err, lat);
    $display("txn LHU 0x016 after reset -> rdata=%h err=%0b lat=%0d", rd, err, lat);
    check("post-drop LHU", rd, 32'h0000CAFE);
    check("post-drop latency", 32'(lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
